// File: rtl/snell_refract_angle.sv
// Refraction-angle solver: finds theeta2 from n1*sin(theeta1) = n2*sin(theeta2) by binary search
// over a 91-entry sine ROM. Define SNELL_ROUND_NEAREST_EN to round to the nearest degree.
module snell_refract_angle #(
  parameter int unsigned N_W   = 4,
  parameter int unsigned A_W   = 7,
  parameter int unsigned SIN_W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] n1,
  input  logic [N_W-1:0] n2,
  input  logic [A_W-1:0] theeta1,
  output logic           busy,
  output logic           done,
  output logic [A_W-1:0] theeta2,
  output logic           tir,
  output logic           err
);

  localparam int unsigned PW = N_W + SIN_W;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StMult   = 3'd1;
  localparam logic [2:0] StSearch = 3'd2;
`ifdef SNELL_ROUND_NEAREST_EN
  localparam logic [2:0] StRound  = 3'd3;
`endif
  localparam logic [2:0] StDone   = 3'd4;

  localparam logic [A_W-1:0] AngMax = A_W'(90);

  // Entry d = round(sin(d deg) * 65535); the table is built for SIN_W = 16.
  function automatic logic [SIN_W-1:0] sin_rom(input logic [A_W-1:0] d);
    logic [15:0] s;
    case (int'(d))
      0:  s = 16'd0;     1:  s = 16'd1144;  2:  s = 16'd2287;  3:  s = 16'd3430;
      4:  s = 16'd4571;  5:  s = 16'd5712;  6:  s = 16'd6850;  7:  s = 16'd7987;
      8:  s = 16'd9121;  9:  s = 16'd10252; 10: s = 16'd11380; 11: s = 16'd12505;
      12: s = 16'd13625; 13: s = 16'd14742; 14: s = 16'd15854; 15: s = 16'd16962;
      16: s = 16'd18064; 17: s = 16'd19161; 18: s = 16'd20251; 19: s = 16'd21336;
      20: s = 16'd22414; 21: s = 16'd23486; 22: s = 16'd24550; 23: s = 16'd25607;
      24: s = 16'd26655; 25: s = 16'd27696; 26: s = 16'd28729; 27: s = 16'd29752;
      28: s = 16'd30767; 29: s = 16'd31772; 30: s = 16'd32768; 31: s = 16'd33753;
      32: s = 16'd34728; 33: s = 16'd35693; 34: s = 16'd36647; 35: s = 16'd37589;
      36: s = 16'd38521; 37: s = 16'd39440; 38: s = 16'd40347; 39: s = 16'd41243;
      40: s = 16'd42125; 41: s = 16'd42995; 42: s = 16'd43851; 43: s = 16'd44695;
      44: s = 16'd45524; 45: s = 16'd46340; 46: s = 16'd47142; 47: s = 16'd47929;
      48: s = 16'd48702; 49: s = 16'd49460; 50: s = 16'd50203; 51: s = 16'd50930;
      52: s = 16'd51642; 53: s = 16'd52339; 54: s = 16'd53019; 55: s = 16'd53683;
      56: s = 16'd54331; 57: s = 16'd54962; 58: s = 16'd55577; 59: s = 16'd56174;
      60: s = 16'd56755; 61: s = 16'd57318; 62: s = 16'd57864; 63: s = 16'd58392;
      64: s = 16'd58902; 65: s = 16'd59395; 66: s = 16'd59869; 67: s = 16'd60325;
      68: s = 16'd60763; 69: s = 16'd61182; 70: s = 16'd61583; 71: s = 16'd61965;
      72: s = 16'd62327; 73: s = 16'd62671; 74: s = 16'd62996; 75: s = 16'd63302;
      76: s = 16'd63588; 77: s = 16'd63855; 78: s = 16'd64103; 79: s = 16'd64331;
      80: s = 16'd64539; 81: s = 16'd64728; 82: s = 16'd64897; 83: s = 16'd65047;
      84: s = 16'd65176; 85: s = 16'd65286; 86: s = 16'd65375; 87: s = 16'd65445;
      88: s = 16'd65495; 89: s = 16'd65525; 90: s = 16'd65535;
      default: s = 16'd0;
    endcase
    return SIN_W'(s);
  endfunction

  logic [2:0]     state_q, state_d;
  logic [N_W-1:0] n1_q, n1_d, n2_q, n2_d;
  logic [A_W-1:0] th1_q, th1_d;
  logic [PW-1:0]  p_q, p_d;
  logic [A_W-1:0] lo_q, lo_d, hi_q, hi_d;
  logic [2:0]     cnt_q, cnt_d;
  logic           tir_i_q, tir_i_d, err_i_q, err_i_d;
  logic [A_W-1:0] theeta2_q, theeta2_d;
  logic           tir_q, tir_d, err_q, err_d;

  logic [A_W-1:0] th_addr, mid;
  logic [A_W:0]   mid_sum;
  logic [PW-1:0]  p_mult, q90, q_mid;

  // Out-of-range angles never reach the ROM; the request is flagged as an error instead.
  assign th_addr = (th1_q > AngMax) ? '0 : th1_q;
  assign p_mult  = PW'(n1_q) * PW'(sin_rom(th_addr));
  assign q90     = PW'(n2_q) * PW'(sin_rom(AngMax));
  assign mid_sum = {1'b0, lo_q} + {1'b0, hi_q};
  assign mid     = A_W'(mid_sum >> 1);
  assign q_mid   = PW'(n2_q) * PW'(sin_rom(mid));

`ifdef SNELL_ROUND_NEAREST_EN
  logic [A_W-1:0] lo_m1, res;
  logic [PW-1:0]  q_lo, q_lo_m1;

  assign lo_m1   = lo_q - A_W'(1);
  assign q_lo    = PW'(n2_q) * PW'(sin_rom(lo_q));
  assign q_lo_m1 = PW'(n2_q) * PW'(sin_rom(lo_m1));
`endif

  always_comb begin
    state_d   = state_q;
    n1_d      = n1_q;
    n2_d      = n2_q;
    th1_d     = th1_q;
    p_d       = p_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cnt_d     = cnt_q;
    tir_i_d   = tir_i_q;
    err_i_d   = err_i_q;
    theeta2_d = theeta2_q;
    tir_d     = tir_q;
    err_d     = err_q;
`ifdef SNELL_ROUND_NEAREST_EN
    res       = lo_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          n1_d    = n1;
          n2_d    = n2;
          th1_d   = theeta1;
          state_d = StMult;
        end
      end
      StMult: begin
        p_d     = p_mult;
        err_i_d = (n2_q == '0) || (th1_q > AngMax);
        tir_i_d = !err_i_d && (p_mult > q90);
        lo_d    = '0;
        hi_d    = AngMax;
        cnt_d   = '0;
        state_d = StSearch;
      end
      StSearch: begin
        // Seven halvings always cover 0..90, so latency is independent of the operands.
        if (lo_q < hi_q) begin
          if (q_mid >= p_q) hi_d = mid;
          else              lo_d = mid + A_W'(1);
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd6) begin
`ifdef SNELL_ROUND_NEAREST_EN
          state_d = StRound;
`else
          state_d   = StDone;
          theeta2_d = err_i_q ? '0 : (tir_i_q ? AngMax : lo_d);
          tir_d     = tir_i_q;
          err_d     = err_i_q;
`endif
        end
      end
`ifdef SNELL_ROUND_NEAREST_EN
      StRound: begin
        // lo is the ceiling angle; step down when the angle below is strictly closer.
        if ((lo_q != '0) && ((p_q - q_lo_m1) < (q_lo - p_q))) res = lo_m1;
        theeta2_d = err_i_q ? '0 : (tir_i_q ? AngMax : res);
        tir_d     = tir_i_q;
        err_d     = err_i_q;
        state_d   = StDone;
      end
`endif
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      n1_q      <= '0;
      n2_q      <= '0;
      th1_q     <= '0;
      p_q       <= '0;
      lo_q      <= '0;
      hi_q      <= '0;
      cnt_q     <= '0;
      tir_i_q   <= 1'b0;
      err_i_q   <= 1'b0;
      theeta2_q <= '0;
      tir_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      n1_q      <= n1_d;
      n2_q      <= n2_d;
      th1_q     <= th1_d;
      p_q       <= p_d;
      lo_q      <= lo_d;
      hi_q      <= hi_d;
      cnt_q     <= cnt_d;
      tir_i_q   <= tir_i_d;
      err_i_q   <= err_i_d;
      theeta2_q <= theeta2_d;
      tir_q     <= tir_d;
      err_q     <= err_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign theeta2 = theeta2_q;
  assign tir     = tir_q;
  assign err     = err_q;

endmodule
